n_bit_adder: RTL and testbench

- Parameterised unsigned adder: C = A + B, with the carry-out kept as the MSB of a W+1-bit result.
- Provides a combinational result path, C, that is valid within the same delta/settle time with no clock dependency.
- Provides a registered result path, C_q plus out_valid, for use inside clocked datapaths.
- Used as a generic arithmetic leaf cell; the default W=1 gives a 1-bit full-width sum, i.e. a half adder with carry.

---
 rtl/n_bit_adder.sv | 61 ++++++
 tb/tb_n_bit_adder.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/n_bit_adder.sv
// Parameterised unsigned ripple-carry adder with combinational and registered sum paths.
// Optional carry-in port enabled by defining NBIT_ADDER_CARRY_IN_EN.
module n_bit_adder #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
`ifdef NBIT_ADDER_CARRY_IN_EN
  input  logic         cin,
`endif
  input  logic         in_valid,
  output logic [W:0]   C,
  output logic [W:0]   C_q,
  output logic         out_valid
);

  logic [W:0]   carry;
  logic [W-1:0] sum;

`ifdef NBIT_ADDER_CARRY_IN_EN
  assign carry[0] = cin;
`else
  assign carry[0] = 1'b0;
`endif

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign sum[i]       = A[i] ^ B[i] ^ carry[i];
    assign carry[i + 1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
  end

  assign C = {carry[W], sum};

  logic [W:0] sum_d, sum_q;
  logic       valid_d, valid_q;

  // Sum holds when no valid input; the valid flag is a one-cycle pulse per capture.
  always_comb begin
    sum_d   = sum_q;
    valid_d = 1'b0;
    if (in_valid) begin
      sum_d   = C;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      valid_q <= valid_d;
    end
  end

  assign C_q       = sum_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_n_bit_adder.sv
// Self-checking bench for n_bit_adder: W=1 and W=8 instances, plus W=4 with carry-in when enabled.
module tb_n_bit_adder;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // W=1 instance, combinational checks only
  logic       rst1 = 1'b1;
  logic [0:0] a1 = '0, b1 = '0;
  logic       iv1 = 1'b0;
  logic [1:0] c1, cq1;
  logic       ov1;

  n_bit_adder #(.W(1)) u_w1 (
    .clk(clk), .rst_n(rst1), .A(a1), .B(b1), .in_valid(iv1),
    .C(c1), .C_q(cq1), .out_valid(ov1)
  );

  // W=8 instance, combinational and registered checks
  logic       rst8 = 1'b1;
  logic [7:0] a8 = '0, b8 = '0;
  logic       iv8 = 1'b0;
  logic [8:0] c8, cq8;
  logic       ov8;

  n_bit_adder #(.W(8)) u_w8 (
    .clk(clk), .rst_n(rst8), .A(a8), .B(b8), .in_valid(iv8),
    .C(c8), .C_q(cq8), .out_valid(ov8)
  );

`ifdef NBIT_ADDER_CARRY_IN_EN
  logic [3:0] a4 = '0, b4 = '0;
  logic       cin4 = 1'b0;
  logic [4:0] c4, cq4;
  logic       ov4;

  n_bit_adder #(.W(4)) u_w4 (
    .clk(clk), .rst_n(1'b1), .A(a4), .B(b4), .cin(cin4), .in_valid(1'b0),
    .C(c4), .C_q(cq4), .out_valid(ov4)
  );
`endif

  logic [8:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One W=8 clock cycle; compares the registered output against the scoreboard.
  task automatic cyc8(input string tag);
    logic [8:0] e;
    @(posedge clk);
    #1;
    if (ov8) begin
      if (exp_q.size() == 0) begin
        chk({tag, "_unexpected_valid"}, 64'(ov8), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk({tag, "_cq"}, 64'(cq8), 64'(e));
      end
    end
  endtask

  task automatic push8(input logic [7:0] a, input logic [7:0] b);
    a8  = a;
    b8  = b;
    iv8 = 1'b1;
    exp_q.push_back({1'b0, a} + {1'b0, b});
  endtask

  initial begin
    logic [1:0] ref1;
    int         rbad;

    // W=1 exhaustive, no clock dependency
    for (int i = 0; i < 4; i++) begin
      a1 = i[1];
      b1 = i[0];
      #10;
      ref1 = (i == 3) ? 2'b10 : ((i == 0) ? 2'b00 : 2'b01);
      chk($sformatf("w1_combo%0d", i), 64'(c1), 64'(ref1));
    end

    // W=1 random, a mismatch stops the run
    rbad = bad;
    for (int i = 0; i < 10; i++) begin
      a1 = 1'($urandom_range(0, 1));
      b1 = 1'($urandom_range(0, 1));
      #10;
      chk($sformatf("w1_rand%0d", i), 64'(c1), 64'({1'b0, a1} + {1'b0, b1}));
    end
    if (bad != rbad) $fatal(1, "FAIL w1_rand stopping after %0d bad", bad - rbad);

    // W=8 combinational boundaries
    a8 = 8'hFF; b8 = 8'h01; #10;
    chk("w8_ff_01", 64'(c8), 64'h100);
    a8 = 8'hFF; b8 = 8'hFF; #10;
    chk("w8_ff_ff", 64'(c8), 64'h1FE);
    a8 = 8'h00; b8 = 8'h00; #10;
    chk("w8_zero", 64'(c8), 64'h000);

    // Reset for two edges
    @(negedge clk);
    rst8 = 1'b0;
    iv8  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("w8_rst_cq", 64'(cq8), 64'd0);
    chk("w8_rst_ov", 64'(ov8), 64'd0);

    // Single capture with carry-out
    @(negedge clk);
    rst8 = 1'b1;
    push8(8'h80, 8'h80);
    cyc8("w8_cap");
    chk("w8_cap_ov", 64'(ov8), 64'd1);

    // Hold with in_valid low
    @(negedge clk);
    iv8 = 1'b0;
    cyc8("w8_hold");
    chk("w8_hold_cq", 64'(cq8), 64'h100);
    chk("w8_hold_ov", 64'(ov8), 64'd0);

    // Back-to-back valids
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      push8(8'($urandom), 8'($urandom));
      cyc8($sformatf("w8_b2b%0d", i));
      chk($sformatf("w8_b2b%0d_ov", i), 64'(ov8), 64'd1);
    end
    chk("w8_b2b_drained", 64'(exp_q.size()), 64'd0);

    // Reset mid-stream discards the in-flight sum
    @(negedge clk);
    a8   = 8'h12;
    b8   = 8'h34;
    iv8  = 1'b1;
    rst8 = 1'b0;
    @(posedge clk);
    #1;
    chk("w8_midrst_cq", 64'(cq8), 64'd0);
    chk("w8_midrst_ov", 64'(ov8), 64'd0);
    chk("w8_midrst_c", 64'(c8), 64'h046);
    @(negedge clk);
    iv8  = 1'b0;
    rst8 = 1'b1;

`ifdef NBIT_ADDER_CARRY_IN_EN
    a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1; #10;
    chk("w4_cin1", 64'(c4), 64'h1F);
    cin4 = 1'b0; #10;
    chk("w4_cin0", 64'(c4), 64'h1E);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
